serial_rx: RTL and testbench
============================

SERIAL_RX -- requirements
Module: serial_rx

Interface
- REQ-001 SHALL have parameter CLKS_PER_BIT, default 16; clock cycles per serial bit, legal range 4..255, even values only.
- REQ-002 SHALL have parameter PARITY_EN, default 1; 1 = even-parity bit present between the data bits and the stop bit, 0 = no parity bit.
- REQ-003 SHALL have port Clk, input, 1 bit; the single clock, and all state changes on its rising edge.
- REQ-004 SHALL have port reset, input, 1 bit; asynchronous, active-low reset.
- REQ-005 SHALL have port en, input, 1 bit; receiver enable, high = armed.
- REQ-006 SHALL have port rx, input, 1 bit; asynchronous serial line, idle high.
- REQ-007 SHALL have port data, output, 8 bits; last good byte received, LSB first on the line.
- REQ-008 SHALL have port valid, output, 1 bit; one-cycle pulse when data updates.
- REQ-009 SHALL have port parity_err, output, 1 bit; one-cycle pulse on parity mismatch.
- REQ-010 SHALL have port frame_err, output, 1 bit; one-cycle pulse when the stop bit is sampled low.
- REQ-011 SHALL have port busy, output, 1 bit; high in any state other than IDLE.

Function
- REQ-012 SHALL pass rx through a 2-flop synchronizer; all decisions use the synchronized value (rx_s).
- REQ-013 SHALL implement states IDLE, START, DATA, PARITY, STOP, WAIT_HIGH.
- REQ-014 IDLE: when en=1 and a falling edge of rx_s is detected, SHALL go to START and clear the tick counter.
- REQ-015 START: at tick CLKS_PER_BIT/2-1, SHALL go to DATA if rx_s=0; otherwise SHALL return to IDLE as a glitch, with no error pulse.
- REQ-016 DATA: SHALL sample rx_s every CLKS_PER_BIT cycles (bit centre) into shift bit index 0..7, LSB first; after bit 7 SHALL go to PARITY if PARITY_EN=1, else to STOP.
- REQ-017 PARITY: SHALL sample at bit centre; the mismatch flag is set if XOR of 8 data bits and the parity bit is 1.
- REQ-018 STOP, rx_s=1 at bit centre: SHALL, on the next cycle, load data and pulse valid, or pulse parity_err instead of valid if the mismatch flag is set; then go to IDLE.
- REQ-019 STOP, rx_s=0 at bit centre: SHALL, on the next cycle, pulse frame_err, not pulse valid, keep data unchanged, and go to WAIT_HIGH.
- REQ-020 WAIT_HIGH: SHALL stay until rx_s=1, then go to IDLE, so a break condition yields exactly one frame_err.
- REQ-021 Latency: valid SHALL rise exactly 1 Clk cycle after the stop-bit centre sample.
- REQ-022 en deasserted in any state SHALL abort the frame, go to IDLE on the next edge, and produce no pulses; data SHALL hold.
- REQ-023 valid, parity_err and frame_err SHALL be mutually exclusive and never high for more than 1 cycle.
- REQ-024 The tick counter SHALL be $clog2(CLKS_PER_BIT) bits wide and wrap to 0 at CLKS_PER_BIT-1; the bit index SHALL be 3 bits and not wrap within a frame.

Reset
- REQ-025 reset=0 SHALL immediately force state=IDLE, data=8'h00, valid=parity_err=frame_err=busy=0, counters=0, and both synchronizer flops=1.
- REQ-026 reset asserted mid-frame SHALL discard the partial byte; after release, reception restarts only on a new falling edge.

Structure
- REQ-027 A shared package SHALL hold the state enum (rx_state_t) and the constant DATA_BITS=8.
- REQ-028 One sub-module, rx_sync2, SHALL implement the 2-flop synchronizer with reset-to-1.

Verification
- REQ-029 Using CLKS_PER_BIT=4, PARITY_EN=1: send byte 8'hA5 with parity 0 and stop 1 -> data=8'hA5, valid high for 1 cycle, no errors.
- REQ-030 Send 8'h3C with parity 1 -> parity_err pulses once, valid=0, data keeps its prior value 8'hA5.
- REQ-031 Send 8'h0F with stop bit 0, then hold rx low for 20 cycles -> exactly one frame_err, busy high until rx returns high.
- REQ-032 Send a 1-cycle low glitch on rx while idle -> no pulses, busy returns low within 4 cycles.
- REQ-033 Pulse reset low for 1 cycle during data bit 3 of 8'hFF, then send 8'h81 -> only one valid, with data=8'h81.
- REQ-034 Drop en during data bit 5, raise it again, then send 8'h42 -> the aborted frame produces nothing, then valid with data=8'h42.

Source files
------------

// File: rtl/serial_rx_pkg.sv
// ============================================================================
// serial_rx_pkg : shared receiver state encoding and frame constants
// Revision      : 1.0
// ============================================================================
`default_nettype none

package serial_rx_pkg;

  localparam int DATA_BITS = 8;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    PARITY    = 3'd3,
    STOP      = 3'd4,
    WAIT_HIGH = 3'd5
  } rx_state_t;

endpackage

`default_nettype wire

// File: rtl/rx_sync2.sv
// ============================================================================
// rx_sync2 : two-flop synchronizer for the serial line, resets to idle-high
// Revision : 1.0
// ============================================================================
`default_nettype none

module rx_sync2 (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

`default_nettype wire

// File: rtl/serial_rx.sv
// ============================================================================
// serial_rx : oversampling UART-style receiver, optional even parity
// Revision  : 1.0
// ============================================================================
`default_nettype none

module serial_rx
  import serial_rx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int PARITY_EN    = 1
) (
  input  logic                 Clk,
  input  logic                 reset,
  input  logic                 en,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data,
  output logic                 valid,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 busy
);

  localparam int               CNT_W    = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [2:0]       BIT_LAST = 3'(DATA_BITS - 1);

  logic                 rx_s;
  logic                 rx_prev_q;
  rx_state_t            state_q;
  logic [CNT_W-1:0]     cnt_q;
  logic [CNT_W-1:0]     cnt_d;
  logic                 tick_last;
  logic [2:0]           bit_idx_q;
  logic [DATA_BITS-1:0] shift_q;
  logic                 mismatch_q;
  logic [DATA_BITS-1:0] data_q;
  logic                 valid_q;
  logic                 parity_err_q;
  logic                 frame_err_q;

  rx_sync2 u_sync (
    .clk_i  (Clk),
    .rst_ni (reset),
    .d_i    (rx),
    .q_o    (rx_s)
  );

  assign tick_last = (cnt_q == CNT_LAST);
  assign cnt_d     = tick_last ? '0 : cnt_q + 1'b1;

  always_ff @(posedge Clk or negedge reset) begin
    if (!reset) begin
      rx_prev_q    <= 1'b1;
      state_q      <= IDLE;
      cnt_q        <= '0;
      bit_idx_q    <= '0;
      shift_q      <= '0;
      mismatch_q   <= 1'b0;
      data_q       <= '0;
      valid_q      <= 1'b0;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      rx_prev_q    <= rx_s;
      valid_q      <= 1'b0;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
      if (!en) begin
        // Disarming abandons any frame in flight without reporting it.
        state_q   <= IDLE;
        cnt_q     <= '0;
        bit_idx_q <= '0;
      end else begin
        case (state_q)
          IDLE: begin
            cnt_q     <= '0;
            bit_idx_q <= '0;
            if (rx_prev_q && !rx_s) begin
              state_q    <= START;
              mismatch_q <= 1'b0;
            end
          end
          START: begin
            if (cnt_q == CNT_HALF) begin
              cnt_q   <= '0;
              state_q <= rx_s ? IDLE : DATA;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
          DATA: begin
            cnt_q <= cnt_d;
            if (tick_last) begin
              shift_q <= {rx_s, shift_q[DATA_BITS-1:1]};
              if (bit_idx_q == BIT_LAST) begin
                state_q <= (PARITY_EN != 0) ? PARITY : STOP;
              end else begin
                bit_idx_q <= bit_idx_q + 3'd1;
              end
            end
          end
          PARITY: begin
            cnt_q <= cnt_d;
            if (tick_last) begin
              mismatch_q <= (^shift_q) ^ rx_s;
              state_q    <= STOP;
            end
          end
          STOP: begin
            cnt_q <= cnt_d;
            if (tick_last) begin
              if (rx_s) begin
                if (mismatch_q) begin
                  parity_err_q <= 1'b1;
                end else begin
                  data_q  <= shift_q;
                  valid_q <= 1'b1;
                end
                state_q <= IDLE;
              end else begin
                frame_err_q <= 1'b1;
                state_q     <= WAIT_HIGH;
              end
            end
          end
          WAIT_HIGH: begin
            // A held-low line (break) is reported once, then ignored until it releases.
            cnt_q <= '0;
            if (rx_s) begin
              state_q <= IDLE;
            end
          end
          default: begin
            state_q <= IDLE;
            cnt_q   <= '0;
          end
        endcase
      end
    end
  end

  assign data       = data_q;
  assign valid      = valid_q;
  assign parity_err = parity_err_q;
  assign frame_err  = frame_err_q;
  assign busy       = (state_q != IDLE);

endmodule

`default_nettype wire

// File: tb/tb_serial_rx.sv
// ============================================================================
// tb_serial_rx : directed and random frames against a frame-level model
// Revision     : 1.0
// ============================================================================
`default_nettype none

module tb_serial_rx;

  localparam int CPB = 4;
  localparam int PE  = 1;
  // Edge to valid: 2 sync flops + edge detect, half a bit, then data/parity/stop bits.
  localparam int LAT = 3 + CPB / 2 + (8 + PE + 1) * CPB;

  logic       Clk;
  logic       reset;
  logic       en;
  logic       rx;
  logic [7:0] data;
  logic       valid;
  logic       parity_err;
  logic       frame_err;
  logic       busy;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int n_valid = 0, n_perr = 0, n_ferr = 0, viol = 0;
  int s_valid, s_perr, s_ferr;
  int last_valid_cyc = -1;
  int start_cyc = 0;
  logic pv = 1'b0, pp = 1'b0, pf = 1'b0;
  logic [7:0] exp_data;

  serial_rx #(.CLKS_PER_BIT(CPB), .PARITY_EN(PE)) dut (
    .Clk        (Clk),
    .reset      (reset),
    .en         (en),
    .rx         (rx),
    .data       (data),
    .valid      (valid),
    .parity_err (parity_err),
    .frame_err  (frame_err),
    .busy       (busy)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  always @(posedge Clk) cyc <= cyc + 1;

  always @(negedge Clk) begin
    if (valid) begin
      n_valid++;
      last_valid_cyc = cyc;
    end
    if (parity_err) n_perr++;
    if (frame_err)  n_ferr++;
    if ($countones({valid, parity_err, frame_err}) > 1) viol++;
    if ((valid && pv) || (parity_err && pp) || (frame_err && pf)) viol++;
    pv = valid;
    pp = parity_err;
    pf = frame_err;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge Clk);
    #1;
  endtask

  task automatic drive_bit(input logic v);
    rx = v;
    cycles(CPB);
  endtask

  task automatic snap();
    s_valid = n_valid;
    s_perr  = n_perr;
    s_ferr  = n_ferr;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic par, input logic stop);
    start_cyc = cyc;
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
    drive_bit(par);
    drive_bit(stop);
  endtask

  task automatic expect_outcome(input string tag, input int dv, input int dp, input int df);
    check({tag, "_valid"}, 32'(n_valid - s_valid), 32'(dv));
    check({tag, "_perr"},  32'(n_perr - s_perr),   32'(dp));
    check({tag, "_ferr"},  32'(n_ferr - s_ferr),   32'(df));
    check({tag, "_data"},  32'(data),              32'(exp_data));
    if (dv == 1) check({tag, "_lat"}, 32'(last_valid_cyc), 32'(start_cyc + LAT));
  endtask

  initial begin
    logic [7:0] b;
    logic       bad_par, bad_stop;

    reset = 1'b0;
    en    = 1'b1;
    rx    = 1'b1;
    exp_data = 8'h00;
    cycles(3);
    check("rst_data",  32'(data),       32'h0);
    check("rst_valid", 32'(valid),      32'h0);
    check("rst_perr",  32'(parity_err), 32'h0);
    check("rst_ferr",  32'(frame_err),  32'h0);
    check("rst_busy",  32'(busy),       32'h0);
    reset = 1'b1;
    cycles(2 * CPB);

    // Good byte with correct even parity.
    snap();
    send_frame(8'hA5, 1'b0, 1'b1);
    cycles(3 * CPB);
    exp_data = 8'hA5;
    expect_outcome("a5", 1, 0, 0);

    // Wrong parity: error pulse, data holds.
    snap();
    send_frame(8'h3C, 1'b1, 1'b1);
    cycles(3 * CPB);
    expect_outcome("3c_par", 0, 1, 0);

    // Stop bit low followed by a break.
    snap();
    send_frame(8'h0F, 1'b0, 1'b0);
    cycles(20);
    check("brk_busy_low", 32'(busy), 32'h1);
    rx = 1'b1;
    cycles(6);
    check("brk_busy_rel", 32'(busy), 32'h0);
    expect_outcome("brk", 0, 0, 1);

    // Single-cycle glitch while idle.
    snap();
    rx = 1'b0;
    cycles(1);
    rx = 1'b1;
    cycles(5);
    check("glitch_busy", 32'(busy), 32'h0);
    cycles(2 * CPB);
    expect_outcome("glitch", 0, 0, 0);

    // Reset pulse during data bit 3 of 0xFF.
    snap();
    drive_bit(1'b0);
    for (int i = 0; i < 3; i++) drive_bit(1'b1);
    rx = 1'b1;
    cycles(2);
    reset = 1'b0;
    #1;
    check("arst_busy", 32'(busy), 32'h0);
    check("arst_data", 32'(data), 32'h0);
    @(posedge Clk);
    #1;
    reset = 1'b1;
    exp_data = 8'h00;
    cycles(4 * CPB);
    expect_outcome("rst_mid", 0, 0, 0);
    snap();
    send_frame(8'h81, 1'b0, 1'b1);
    cycles(3 * CPB);
    exp_data = 8'h81;
    expect_outcome("81", 1, 0, 0);

    // Disarm during data bit 5, line finishes the frame, then rearm.
    snap();
    b = 8'($urandom);
    drive_bit(1'b0);
    for (int i = 0; i < 5; i++) drive_bit(b[i]);
    rx = b[5];
    cycles(2);
    en = 1'b0;
    cycles(CPB - 2);
    for (int i = 6; i < 8; i++) drive_bit(b[i]);
    drive_bit(^b);
    drive_bit(1'b1);
    cycles(2 * CPB);
    check("en_busy", 32'(busy), 32'h0);
    en = 1'b1;
    cycles(2 * CPB);
    expect_outcome("en_abort", 0, 0, 0);
    snap();
    send_frame(8'h42, 1'b0, 1'b1);
    cycles(3 * CPB);
    exp_data = 8'h42;
    expect_outcome("42", 1, 0, 0);

    // Random frames: model keeps the last good byte and classifies each frame.
    for (int k = 0; k < 10; k++) begin
      b        = 8'($urandom);
      bad_par  = ($urandom_range(0, 3) == 0);
      bad_stop = ($urandom_range(0, 3) == 0);
      snap();
      send_frame(b, (^b) ^ bad_par, !bad_stop);
      if (bad_stop) cycles($urandom_range(1, 8));
      rx = 1'b1;
      cycles(3 * CPB + $urandom_range(0, 5));
      if (bad_stop) expect_outcome("rnd_stop", 0, 0, 1);
      else if (bad_par) expect_outcome("rnd_par", 0, 1, 0);
      else begin
        exp_data = b;
        expect_outcome("rnd_ok", 1, 0, 0);
      end
    end

    check("pulse_excl", 32'(viol), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
